// File: rtl/block_mem_responder.sv
// block_mem_responder: fixed-latency 128-bit block memory answering L1 cache reads and write-backs
//
// One request in flight at a time. A request accepted on a rising edge (req_valid & req_ready)
// is answered LATENCY edges later with a one-cycle resp_valid pulse. Writes commit on the edge
// that enters the response cycle, so a reset during the response cycle keeps the write.
//
// Build option: define MEM_STATS_EN to add the read_count/write_count ports and their
// saturating counters; without it those ports and that logic do not exist.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (store contents are kept)
//   req_valid    request present
//   req_ready    idle, request can be accepted
//   req_write    0 = block read, 1 = block write-back
//   req_addr     byte address; block index taken from bits above the 16-byte offset
//   req_data     write-back block, word0 in [31:0]
//   resp_valid   one-cycle completion pulse
//   resp_data    block read data; only updated by reads
//   read_count   completed reads (MEM_STATS_EN)
//   write_count  completed writes (MEM_STATS_EN)
module block_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int NUM_BLOCKS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [9:0]   req_addr,
    input  logic [127:0] req_data,
    output logic         resp_valid,
    output logic [127:0] resp_data
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
`endif
);
    localparam int IW = $clog2(NUM_BLOCKS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          cap_write;
    logic [IW-1:0] cap_idx;
    logic [127:0]  cap_data;
    logic          done;
    logic          unused_offset;

    // The power-up image is generated from the block index, so only blocks that have been
    // written back need real storage contents; the written mask selects between the two.
    logic [127:0]          store [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] written = '0;

    // Power-up image: the word at byte address a holds a >> 2, i.e. {index, word number}.
    function automatic logic [127:0] init_block(input logic [IW-1:0] i);
        logic [127:0] b;
        b = '0;
        for (int w = 0; w < 4; w++) b[32*w +: 32] = {{(30-IW){1'b0}}, i, 2'(w)};
        return b;
    endfunction

    assign req_ready     = state == IDLE;
    assign resp_valid    = state == RESP;
    assign done          = state == WAIT && cnt == 4'd0;
    assign unused_offset = ^req_addr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state     <= WAIT;
                    cnt       <= 4'(LATENCY - 1);
                    cap_write <= req_write;
                    cap_idx   <= req_addr[4 +: IW];
                    cap_data  <= req_data;
                end
                WAIT: if (cnt == 4'd0) begin
                    state <= RESP;
                    if (!cap_write) resp_data <= written[cap_idx] ? store[cap_idx] : init_block(cap_idx);
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, so an aborted access never reaches done.
    always_ff @(posedge clk) begin
        if (done && cap_write) begin
            store[cap_idx]   <= cap_data;
            written[cap_idx] <= 1'b1;
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else if (state == RESP) begin
            if (cap_write && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            if (!cap_write && read_count != 16'hFFFF) read_count <= read_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: table-driven and sequence checks for block_mem_responder
module tb_block_mem_responder;
    logic         clk;
    logic         rst_n;
    logic [1:0]   vld;
    logic         req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_data;
    logic [1:0]   rdy;
    logic [1:0]   rv;
    logic [127:0] rd [2];
    int           checks = 0;
    int           failures = 0;
`ifdef MEM_STATS_EN
    logic [15:0]  rc [2];
    logic [15:0]  wc [2];
`endif

    block_mem_responder #(.LATENCY(4), .NUM_BLOCKS(64)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(rv[0]), .resp_data(rd[0])
`ifdef MEM_STATS_EN
        , .read_count(rc[0]), .write_count(wc[0])
`endif
    );

    block_mem_responder #(.LATENCY(1), .NUM_BLOCKS(64)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(rv[1]), .resp_data(rd[1])
`ifdef MEM_STATS_EN
        , .read_count(rc[1]), .write_count(wc[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         w;
        logic [9:0]   a;
        logic [127:0] d;
        logic [127:0] e;
        string        n;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request on DUT d, wait for acceptance and response, check latency, data and pulse width.
    task automatic do_req(input int d, input logic w, input logic [9:0] a, input logic [127:0] dat,
                          input logic [127:0] exp, input int lat, input string name);
        int n;
        req_write = w;
        req_addr  = a;
        req_data  = dat;
        vld[d]    = 1'b1;
        n = 0;
        while (!rdy[d] && n < 50) begin
            tick();
            n++;
        end
        chk({name, " ready"}, 128'(rdy[d]), 128'(1));
        tick();
        vld[d]    = 1'b0;
        req_addr  = ~a;
        req_data  = ~dat;
        req_write = ~w;
        n = 0;
        while (!rv[d] && n < 50) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 128'(n), 128'(lat));
        chk({name, " data"}, rd[d], exp);
        tick();
        chk({name, " pulse"}, 128'(rv[d]), 128'(0));
    endtask

    initial begin
        int gap;
        int busy;
        int n;
        tbl[0] = '{1'b0, 10'h010, 128'h0, 128'h00000007_00000006_00000005_00000004, "rd_blk1"};
        tbl[1] = '{1'b1, 10'h3F0, {4{32'hDEADBEEF}}, 128'h00000007_00000006_00000005_00000004, "wr_blk63"};
        tbl[2] = '{1'b0, 10'h3F4, 128'h0, {4{32'hDEADBEEF}}, "rd_blk63"};
        tbl[3] = '{1'b0, 10'h000, 128'h0, 128'h00000003_00000002_00000001_00000000, "rd_blk0"};
        tbl[4] = '{1'b0, 10'h1A3, 128'h0, 128'h0000006B_0000006A_00000069_00000068, "rd_blk26"};
        tbl[5] = '{1'b1, 10'h100, 128'h11111111_22222222_33333333_44444444,
                   128'h0000006B_0000006A_00000069_00000068, "wr_blk16"};
        tbl[6] = '{1'b0, 10'h10C, 128'h0, 128'h11111111_22222222_33333333_44444444, "rd_blk16"};

        rst_n = 1'b0;
        vld = 2'b00;
        req_write = 1'b0;
        req_addr = 10'h0;
        req_data = 128'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ready %0d", d), 128'(rdy[d]), 128'(1));
            chk($sformatf("reset valid %0d", d), 128'(rv[d]), 128'(0));
            chk($sformatf("reset data %0d", d), rd[d], 128'h0);
        end

        for (int i = 0; i < 7; i++) do_req(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, 4, tbl[i].n);
`ifdef MEM_STATS_EN
        chk("read_count", 128'(rc[0]), 128'(5));
        chk("write_count", 128'(wc[0]), 128'(2));
`endif

        // Request held during WAIT is not accepted until the first IDLE cycle.
        req_write = 1'b0;
        req_addr  = 10'h020;
        vld[0]    = 1'b1;
        tick();
        req_addr = 10'h030;
        gap = -1;
        busy = 0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j <= 4 && rdy[0]) busy++;
            if (j == 4) chk("held first data", rd[0], 128'h0000000B_0000000A_00000009_00000008);
            if (rdy[0] && gap < 0) gap = j + 1;
        end
        chk("held ready low", 128'(busy), 128'(0));
        chk("held accept gap", 128'(gap), 128'(6));
        tick();
        vld[0] = 1'b0;
        n = 0;
        while (!rv[0] && n < 50) begin
            tick();
            n++;
        end
        chk("held second latency", 128'(n), 128'(4));
        chk("held second data", rd[0], 128'h0000000F_0000000E_0000000D_0000000C);
        tick();

        // Reset two cycles into a write aborts it.
        req_write = 1'b1;
        req_addr  = 10'h020;
        req_data  = {4{32'h55555555}};
        vld[0]    = 1'b1;
        tick();
        vld[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort ready", 128'(rdy[0]), 128'(1));
        chk("abort valid", 128'(rv[0]), 128'(0));
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (rv[0]) n++;
        end
        chk("abort no resp", 128'(n), 128'(0));
        do_req(0, 1'b0, 10'h020, 128'h0, 128'h0000000B_0000000A_00000009_00000008, 4, "abort readback");

        // Reset during the response cycle keeps the committed write.
        req_write = 1'b1;
        req_addr  = 10'h050;
        req_data  = {4{32'hAAAAAAAA}};
        vld[0]    = 1'b1;
        tick();
        vld[0] = 1'b0;
        n = 0;
        while (!rv[0] && n < 50) begin
            tick();
            n++;
        end
        chk("resp-reset latency", 128'(n), 128'(4));
        rst_n = 1'b0;
        #1;
        chk("resp-reset valid", 128'(rv[0]), 128'(0));
        chk("resp-reset data", rd[0], 128'h0);
        tick();
        rst_n = 1'b1;
`ifdef MEM_STATS_EN
        chk("reset read_count", 128'(rc[0]), 128'(0));
        chk("reset write_count", 128'(wc[0]), 128'(0));
`endif
        do_req(0, 1'b0, 10'h050, 128'h0, {4{32'hAAAAAAAA}}, 4, "resp-reset readback");

        // Latency 1, back-to-back reads.
        do_req(1, 1'b0, 10'h000, 128'h0, 128'h00000003_00000002_00000001_00000000, 1, "lat1 blk0");
        do_req(1, 1'b0, 10'h3FF, 128'h0, 128'h000000FF_000000FE_000000FD_000000FC, 1, "lat1 blk63");
`ifdef MEM_STATS_EN
        chk("lat1 read_count", 128'(rc[1]), 128'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
